// File: rtl/mem_access.sv
// RV32I memory-access stage: runs one load/store at a time over a req/ack data bus,
// stalls execute while the access is in flight and registers results toward write-back.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [4:0]  ALUop_i,
    input  logic        WriteReg_i,
    input  logic [4:0]  WriteDataNum_i,
    input  logic [31:0] WriteData_i,
    input  logic [31:0] MemAddr_i,
    input  logic [31:0] StoreData_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        valid_o,
    output logic        WriteReg_o,
    output logic [4:0]  WriteDataNum_o,
    output logic [31:0] WriteData_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o
);
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, mwdata_q, mwdata_d;
    logic [3:0]  be_q, be_d;
    logic        valid_q, valid_d, wreg_q, wreg_d, err_q, err_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cause_q, cause_d;
    // Per-access context needed when the ack returns.
    logic [2:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic        pwreg_q, pwreg_d;
    logic [4:0]  prd_q, prd_d;

    logic        is_mem, is_store, sz_word, sz_half, misaligned, timeout_hit;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec, load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign is_mem = (ALUop_i[4:3] == 2'b10);

    always_comb begin
        is_store = 1'b0;
        sz_word  = 1'b0;
        sz_half  = 1'b0;
        case (ALUop_i[2:0])
            3'b000:         sz_word = 1'b1;
            3'b001, 3'b011: sz_half = 1'b1;
            3'b101: begin sz_word = 1'b1; is_store = 1'b1; end
            3'b110: begin sz_half = 1'b1; is_store = 1'b1; end
            3'b111:         is_store = 1'b1;
            default: ;
        endcase
    end

    assign misaligned = (sz_word && (MemAddr_i[1:0] != 2'b00)) || (sz_half && MemAddr_i[0]);
    assign be_dec     = sz_word ? 4'b1111 :
                        sz_half ? (MemAddr_i[1] ? 4'b1100 : 4'b0011) :
                        (4'b0001 << MemAddr_i[1:0]);
    assign wdata_dec  = sz_word ? StoreData_i :
                        sz_half ? {2{StoreData_i[15:0]}} : {4{StoreData_i[7:0]}};

    // An ack in the final allowed cycle completes normally instead of timing out.
    assign timeout_hit = (state_q == REQ) && !mem_ack_i && (cnt_q == TO_LAST);

    assign byte_sel = mem_rdata_i[{lane_q, 3'b000} +: 8];
    assign half_sel = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        case (op_q)
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b011:  load_val = {16'b0, half_sel};
            3'b100:  load_val = {24'b0, byte_sel};
            default: load_val = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i && is_mem && !misaligned) state_d = REQ;
            REQ:     if (mem_ack_i || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            IDLE:    stall_o = valid_i && is_mem && !misaligned;
            REQ:     stall_o = !mem_ack_i && !timeout_hit;
            default: stall_o = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        mwdata_d = mwdata_q;
        valid_d  = 1'b0;
        wreg_d   = wreg_q;
        rd_d     = rd_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        cause_d  = cause_q;
        op_d     = op_q;
        lane_d   = lane_q;
        pwreg_d  = pwreg_q;
        prd_d    = prd_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!is_mem) begin
                        valid_d = 1'b1;
                        wreg_d  = WriteReg_i;
                        rd_d    = WriteDataNum_i;
                        wdata_d = WriteData_i;
                    end else if (misaligned) begin
                        valid_d = 1'b1;
                        wreg_d  = 1'b0;
                        rd_d    = WriteDataNum_i;
                        err_d   = 1'b1;
                        cause_d = is_store ? 2'b10 : 2'b01;
                    end else begin
                        req_d    = 1'b1;
                        we_d     = is_store;
                        addr_d   = {MemAddr_i[31:2], 2'b00};
                        be_d     = be_dec;
                        mwdata_d = wdata_dec;
                        cnt_d    = 8'd0;
                        op_d     = ALUop_i[2:0];
                        lane_d   = MemAddr_i[1:0];
                        pwreg_d  = WriteReg_i;
                        prd_d    = WriteDataNum_i;
                    end
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    rd_d    = prd_q;
                    if (we_q) begin
                        wreg_d = 1'b0;
                    end else begin
                        wreg_d  = pwreg_q;
                        wdata_d = load_val;
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    wreg_d  = 1'b0;
                    rd_d    = prd_q;
                    err_d   = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            mwdata_q <= '0;
            valid_q  <= 1'b0;
            wreg_q   <= 1'b0;
            rd_q     <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            cause_q  <= '0;
            op_q     <= '0;
            lane_q   <= '0;
            pwreg_q  <= 1'b0;
            prd_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            mwdata_q <= mwdata_d;
            valid_q  <= valid_d;
            wreg_q   <= wreg_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            cause_q  <= cause_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
            pwreg_q  <= pwreg_d;
            prd_q    <= prd_d;
        end
    end

    assign mem_req_o      = req_q;
    assign mem_we_o       = we_q;
    assign mem_addr_o     = addr_q;
    assign mem_be_o       = be_q;
    assign mem_wdata_o    = mwdata_q;
    assign valid_o        = valid_q;
    assign WriteReg_o     = wreg_q;
    assign WriteDataNum_o = rd_q;
    assign WriteData_o    = wdata_q;
    assign err_o          = err_q;
    assign err_cause_o    = cause_q;
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage that sits directly downstream of the execute stage in the RV32I core. It consumes the ALU result, memory address, store data and destination-register fields, and performs loads and stores over a single-outstanding req/ack data-memory bus with byte enables and load sign/zero extension. While a bus transaction is in flight it stalls upstream. Results are registered toward write-back.

## Interface
- `TIMEOUT`, default 255: maximum REQ cycles without ack before abort (1..255).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_i`  in  1  instruction from execute is present.
- `ALUop_i`  in  5  operation code; memory ops listed under Operation.
- `WriteReg_i`  in  1  instruction writes rd.
- `WriteDataNum_i`  in  5  rd index.
- `WriteData_i`  in  32  ALU/link result for non-memory ops.
- `MemAddr_i`  in  32  effective byte address.
- `StoreData_i`  in  32  rs2 value for stores.
- `stall_o`  out  1  combinational; upstream holds all inputs while high.
- `mem_req_o`  out  1  bus request, registered.
- `mem_we_o`  out  1  1 = write.
- `mem_addr_o`  out  32  `{MemAddr_i[31:2],2'b00}`, registered.
- `mem_be_o`  out  4  byte enables, registered.
- `mem_wdata_o`  out  32  lane-replicated store data, registered.
- `mem_ack_i`  in  1  bus completion; read data valid in the same cycle.
- `mem_rdata_i`  in  32  read word.
- `valid_o`  out  1  registered result valid toward write-back.
- `WriteReg_o`  out  1  registered write enable.
- `WriteDataNum_o`  out  5  registered rd.
- `WriteData_o`  out  32  registered result.
- `err_o`  out  1  one-cycle pulse on a faulted access.
- `err_cause_o`  out  2  01 misaligned load, 10 misaligned store, 11 bus timeout; held until the next error.

## Operation
- Memory ALUop codes: 10000 LW, 10001 LH, 10010 LB, 10011 LHU, 10100 LBU, 10101 SW, 10110 SH, 10111 SB. All other codes are pass-through.
- An instruction is consumed at the edge where `valid_i && !stall_o`.
- States: IDLE, REQ.
- IDLE, pass-through op: `stall_o` = 0. On the next edge, `valid_o` = 1 and `WriteData_o`, `WriteReg_o`, `WriteDataNum_o` are copied.
- IDLE, aligned memory op: `stall_o` = 1. On the next edge, go to REQ; drive `mem_req_o` = 1 along with `mem_we_o`, `mem_addr_o`, `mem_be_o` and `mem_wdata_o`; clear the timeout counter.
- Alignment: halfword ops require `addr[0]` = 0; word ops require `addr[1:0]` = 0.
- IDLE, misaligned memory op: no bus access and `stall_o` = 0. On the next edge: `valid_o` = 1, `WriteReg_o` = 0, `err_o` pulses, `err_cause_o` is set.
- Byte enables:
  - SB/LB/LBU: `mem_be_o` = `4'b0001 << addr[1:0]`; `mem_wdata_o` = `{4{StoreData_i[7:0]}}`.
  - SH/LH/LHU: `mem_be_o` = `addr[1] ? 1100 : 0011`; `mem_wdata_o` = `{2{StoreData_i[15:0]}}`.
  - SW/LW: `mem_be_o` = 1111.
- REQ: `stall_o` = `!mem_ack_i`. Bus outputs are held stable until ack.
- On an ack edge, go to IDLE, drop `mem_req_o`, and register outputs:
  - Loads: select the lane by `addr[1:0]` and sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - `WriteReg_o`: copied for loads; forced to 0 for stores.
- Timeout: the counter increments each REQ cycle without ack. When it reaches `TIMEOUT`:
  - drop `mem_req_o`, go to IDLE, and consume the instruction (`stall_o` = 0 that cycle);
  - `valid_o` = 1 and `WriteReg_o` = 0; `err_o` pulses with cause 11.
- An ack arriving in the same cycle the counter reaches `TIMEOUT` wins; no error is raised.
- `mem_ack_i` is ignored in IDLE.
- When `valid_i` = 0 in IDLE, `valid_o` = 0 next cycle and the other registered outputs hold their values.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-REQ): state IDLE; all outputs 0 (`mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_be_o`, `mem_wdata_o`, `valid_o`, `WriteReg_o`, `WriteDataNum_o`, `WriteData_o`, `err_o`, `err_cause_o`); counter 0.
- An in-flight transaction aborted by reset produces no output. A late ack after reset is ignored.
- Latency:
  - pass-through: 1 cycle;
  - misaligned op: 1 cycle;
  - memory op with ack on the first REQ cycle: 2 cycles; each wait cycle adds 1.
- Back-to-back memory ops: the next op issues in the cycle after the ack, with one idle bus cycle between requests.
- Throughput: one pass-through op per cycle.

## Test plan
- Pass-through: `ALUop` 01100, `WriteData_i` = 0x1234, rd = 5, `valid_i` for 3 consecutive cycles -> `valid_o` high 1 cycle later, `WriteData_o` = 0x1234, `stall_o` never high.
- LB, addr 0x103, `mem_rdata_i` = 0x80FF_FFFF, ack after 2 wait cycles -> `mem_be_o` = 1000, `WriteData_o` = 0xFFFF_FF80, `stall_o` high 3 cycles; LBU with the same stimulus -> 0x0000_0080.
- SH, addr 0x22, `StoreData_i` = 0xABCD_1234 -> `mem_we_o` = 1, `mem_be_o` = 1100, `mem_wdata_o` = 0x1234_1234, `mem_addr_o` = 0x20, `WriteReg_o` = 0.
- LW, addr 0x6 -> no `mem_req_o`; `err_o` pulse with cause 01; `valid_o` = 1, `WriteReg_o` = 0.
- `TIMEOUT` = 4 with ack never asserted -> `mem_req_o` high 4 cycles then low, `err_cause_o` = 11; repeat with ack on the 4th cycle -> normal completion, no error.
- Assert `rst` during the 2nd REQ cycle, then assert ack -> `mem_req_o` low immediately, state IDLE, no `valid_o`.
